// File: rtl/fetch_unit_if.sv
// IF/ID output bundle between the fetch stage and decode.
//   if_valid    : IF/ID register holds an instruction (fetch -> decode)
//   if_ready    : decode accepts the instruction this cycle (decode -> fetch)
//   if_instr    : registered instruction
//   if_pc       : byte address of if_instr
//   if_pc_plus4 : if_pc + 4, wrapping at the address width (link value)
// Handshake: a transfer happens on a rising edge where if_valid and if_ready
// are both 1. While if_valid is 1 and if_ready is 0, if_instr, if_pc and
// if_pc_plus4 hold. if_valid may drop without a transfer only on a flush
// (redirect, misaligned redirect, or reset).
interface fetch_unit_if #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
);
  logic                   if_valid;
  logic                   if_ready;
  logic [INS_W-1:0]       if_instr;
  logic [INS_ADDRESS-1:0] if_pc;
  logic [INS_ADDRESS-1:0] if_pc_plus4;

  modport master (
    output if_valid, if_instr, if_pc, if_pc_plus4,
    input  if_ready
  );

  modport slave (
    input  if_valid, if_instr, if_pc, if_pc_plus4,
    output if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, drives the instruction-memory read
// address (memory data returns in the same cycle) and registers instruction
// plus PC into the IF/ID output register toward decode.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_ra         : read address to instruction memory (the PC register)
//   imem_rd         : instruction returned for imem_ra in the same cycle
//   redirect_valid  : taken branch/jal/jalr from execute this cycle
//   redirect_pc     : redirect target byte address
//   halt_req        : stop fetching
//   fetch_err       : sticky misaligned-redirect error
//   dbg_state       : current FSM state (RUN=0, HALT=1, ERR=2)
//   ifid            : IF/ID output bundle (master side)
module fetch_unit #(
  parameter int                     INS_ADDRESS = 9,
  parameter int                     INS_W       = 32,
  parameter logic [INS_ADDRESS-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [INS_ADDRESS-1:0] imem_ra,
  input  logic [INS_W-1:0]       imem_rd,
  input  logic                   redirect_valid,
  input  logic [INS_ADDRESS-1:0] redirect_pc,
  input  logic                   halt_req,
  output logic                   fetch_err,
  output logic [1:0]             dbg_state,
  fetch_unit_if.master           ifid
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [INS_ADDRESS-1:0] pc, pc_n, pc_plus4;
  logic                   valid_q, valid_n;
  logic                   err_q, err_n;
  logic                   capture;
  logic                   load;
  logic [INS_W-1:0]       instr_q;
  logic [INS_ADDRESS-1:0] opc_q, opc_plus4_q;

  assign pc_plus4 = pc + INS_ADDRESS'(4);
  // The output register can take a new word when empty or being drained.
  assign load     = !valid_q || ifid.if_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      instr_q     <= '0;
      opc_q       <= '0;
      opc_plus4_q <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      valid_q <= valid_n;
      err_q   <= err_n;
      if (capture) begin
        instr_q     <= imem_rd;
        opc_q       <= pc;
        opc_plus4_q <= pc_plus4;
      end
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = valid_q;
    err_n   = err_q;
    capture = 1'b0;
    case (state)
      RUN, HALT: begin
        if (redirect_valid) begin
          // Any redirect flushes the wrong-path word, accepted or not.
          valid_n = 1'b0;
          if (redirect_pc[1:0] != 2'b00) begin
            state_n = ERR;
            err_n   = 1'b1;
          end else begin
            state_n = RUN;
            pc_n    = redirect_pc;
          end
        end else if (state == HALT) begin
          if (ifid.if_ready) valid_n = 1'b0;
        end else if (halt_req) begin
          // Entering HALT: no capture; a pending word drains normally.
          state_n = HALT;
          if (ifid.if_ready) valid_n = 1'b0;
        end else if (load) begin
          capture = 1'b1;
          valid_n = 1'b1;
          pc_n    = pc_plus4;
        end
      end
      ERR: begin
        valid_n = 1'b0;
        err_n   = 1'b1;
      end
      default: begin
        state_n = ERR;
        valid_n = 1'b0;
        err_n   = 1'b1;
      end
    endcase
  end

  assign imem_ra          = pc;
  assign fetch_err        = err_q;
  assign dbg_state        = state;
  assign ifid.if_valid    = valid_q;
  assign ifid.if_instr    = instr_q;
  assign ifid.if_pc       = opc_q;
  assign ifid.if_pc_plus4 = opc_plus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int IW = AW + DW + AW;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] imem_ra;
  logic [DW-1:0] imem_rd;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt_req;
  logic          fetch_err;
  logic [1:0]    dbg_state;

  fetch_unit_if #(.INS_ADDRESS(AW), .INS_W(DW)) ifid ();

  fetch_unit #(.INS_ADDRESS(AW), .INS_W(DW), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_ra        (imem_ra),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .fetch_err      (fetch_err),
    .dbg_state      (dbg_state),
    .ifid           (ifid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    case (a)
      9'h000:  return 32'h00007033;
      9'h004:  return 32'h00100093;
      9'h008:  return 32'h00200113;
      9'h030:  return 32'h0014c263;
      9'h054:  return 32'h00008413;
      default: return {16'hA5A5, 7'd0, a};
    endcase
  endfunction

  assign imem_rd = mem_word(imem_ra);

  function automatic logic [IW-1:0] exp_item(input logic [AW-1:0] a);
    logic [AW-1:0] n;
    n = a + AW'(4);
    return {a, mem_word(a), n};
  endfunction

  // ---------------- scoreboard ----------------
  logic [IW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    ifid.if_ready  = 1'b1;
    tick();
    tick();
    total++;
    if ({ifid.if_valid, fetch_err} !== 2'b00) begin
      bad++; $display("FAIL reset_flags got=%b want=00", {ifid.if_valid, fetch_err});
    end
    total++;
    if ({ifid.if_instr, ifid.if_pc, ifid.if_pc_plus4} !== '0) begin
      bad++; $display("FAIL reset_outregs got=%h/%h/%h want=0", ifid.if_instr, ifid.if_pc, ifid.if_pc_plus4);
    end
    total++;
    if (imem_ra !== 9'h000 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL reset_pc got=%h st=%0d want=000 st=0", imem_ra, dbg_state);
    end
  endtask

  task automatic test_sequential();
    logic [IW-1:0] want;
    exp_q.push_back(exp_item(9'h000));
    exp_q.push_back(exp_item(9'h004));
    exp_q.push_back(exp_item(9'h008));
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      want = exp_q.pop_front();
      total++;
      if (ifid.if_valid !== 1'b1 || {ifid.if_pc, ifid.if_instr, ifid.if_pc_plus4} !== want) begin
        bad++;
        $display("FAIL seq_%0d got=v%b %h/%h/%h want=%h", i, ifid.if_valid, ifid.if_pc, ifid.if_instr, ifid.if_pc_plus4, want);
      end
    end
    total++;
    if (imem_ra !== 9'h00C) begin
      bad++; $display("FAIL seq_ra got=%h want=00c", imem_ra);
    end
  endtask

  task automatic test_stall();
    logic [IW-1:0] want;
    ifid.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ifid.if_valid !== 1'b1 || ifid.if_pc !== 9'h008 || ifid.if_instr !== 32'h00200113 || imem_ra !== 9'h00C) begin
        bad++;
        $display("FAIL stall_%0d got=v%b pc=%h ins=%h ra=%h want=v1 008 00200113 00c", i, ifid.if_valid, ifid.if_pc, ifid.if_instr, imem_ra);
      end
    end
    ifid.if_ready = 1'b1;
    exp_q.push_back(exp_item(9'h00C));
    tick();
    want = exp_q.pop_front();
    total++;
    if (ifid.if_valid !== 1'b1 || {ifid.if_pc, ifid.if_instr, ifid.if_pc_plus4} !== want) begin
      bad++; $display("FAIL stall_release got=%h/%h want=%h", ifid.if_pc, ifid.if_instr, want);
    end
  endtask

  task automatic test_halt();
    logic [IW-1:0] want;
    ifid.if_ready = 1'b0;
    halt_req      = 1'b1;
    tick();
    halt_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (ifid.if_valid !== 1'b1 || ifid.if_pc !== 9'h00C || imem_ra !== 9'h010 || dbg_state !== 2'd1) begin
        bad++;
        $display("FAIL halt_hold_%0d got=v%b pc=%h ra=%h st=%0d want=v1 00c 010 1", i, ifid.if_valid, ifid.if_pc, imem_ra, dbg_state);
      end
      tick();
    end
    ifid.if_ready = 1'b1;
    halt_req      = 1'b1;
    tick();
    tick();
    halt_req = 1'b0;
    total++;
    if (ifid.if_valid !== 1'b0 || imem_ra !== 9'h010 || dbg_state !== 2'd1) begin
      bad++; $display("FAIL halt_drain got=v%b ra=%h st=%0d want=v0 010 1", ifid.if_valid, imem_ra, dbg_state);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 9'h030;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (ifid.if_valid !== 1'b0 || imem_ra !== 9'h030 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL halt_exit got=v%b ra=%h st=%0d want=v0 030 0", ifid.if_valid, imem_ra, dbg_state);
    end
    exp_q.push_back(exp_item(9'h030));
    exp_q.push_back(exp_item(9'h034));
    for (int i = 0; i < 2; i++) begin
      tick();
      want = exp_q.pop_front();
      total++;
      if (ifid.if_valid !== 1'b1 || {ifid.if_pc, ifid.if_instr, ifid.if_pc_plus4} !== want) begin
        bad++; $display("FAIL halt_resume_%0d got=%h/%h want=%h", i, ifid.if_pc, ifid.if_instr, want);
      end
    end
  endtask

  task automatic test_redirect();
    logic [IW-1:0] want;
    ifid.if_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 9'h054;
    tick();
    redirect_valid = 1'b0;
    ifid.if_ready  = 1'b1;
    total++;
    if (ifid.if_valid !== 1'b0 || imem_ra !== 9'h054) begin
      bad++; $display("FAIL redir_stall_flush got=v%b ra=%h want=v0 054", ifid.if_valid, imem_ra);
    end
    exp_q.push_back(exp_item(9'h054));
    tick();
    want = exp_q.pop_front();
    total++;
    if (ifid.if_valid !== 1'b1 || {ifid.if_pc, ifid.if_instr, ifid.if_pc_plus4} !== want) begin
      bad++; $display("FAIL redir_target got=%h/%h want=%h", ifid.if_pc, ifid.if_instr, want);
    end
    // redirect while the valid word is being accepted: still flushed
    redirect_valid = 1'b1;
    redirect_pc    = 9'h100;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (ifid.if_valid !== 1'b0 || imem_ra !== 9'h100) begin
      bad++; $display("FAIL redir_accept_flush got=v%b ra=%h want=v0 100", ifid.if_valid, imem_ra);
    end
    exp_q.push_back(exp_item(9'h100));
    tick();
    want = exp_q.pop_front();
    total++;
    if (ifid.if_valid !== 1'b1 || {ifid.if_pc, ifid.if_instr, ifid.if_pc_plus4} !== want) begin
      bad++; $display("FAIL redir_100 got=%h/%h want=%h", ifid.if_pc, ifid.if_instr, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] want;
    logic [IW-1:0] held;
    logic [AW-1:0] next_pc;
    logic          acc;
    held    = exp_item(9'h100);
    next_pc = 9'h104;
    exp_q.push_back(exp_item(next_pc));
    for (int i = 0; i < 40; i++) begin
      ifid.if_ready = 1'($urandom_range(0, 1));
      acc = ifid.if_ready;  // output is valid throughout this run
      tick();
      total++;
      if (acc) begin
        want = exp_q.pop_front();
        next_pc = next_pc + AW'(4);
        exp_q.push_back(exp_item(next_pc));
        held = want;
      end
      if (ifid.if_valid !== 1'b1 || {ifid.if_pc, ifid.if_instr, ifid.if_pc_plus4} !== held) begin
        bad++; $display("FAIL b2b_%0d got=v%b %h/%h want=%h", i, ifid.if_valid, ifid.if_pc, ifid.if_instr, held);
      end
    end
    exp_q.delete();
    ifid.if_ready = 1'b1;
  endtask

  task automatic test_wrap();
    logic [IW-1:0] want;
    redirect_valid = 1'b1;
    redirect_pc    = 9'h1FC;
    tick();
    redirect_valid = 1'b0;
    exp_q.push_back(exp_item(9'h1FC));
    exp_q.push_back(exp_item(9'h000));
    tick();
    want = exp_q.pop_front();
    total++;
    if (ifid.if_valid !== 1'b1 || {ifid.if_pc, ifid.if_instr, ifid.if_pc_plus4} !== want || ifid.if_pc_plus4 !== 9'h000) begin
      bad++; $display("FAIL wrap_1fc got=%h/%h/%h want=%h", ifid.if_pc, ifid.if_instr, ifid.if_pc_plus4, want);
    end
    total++;
    if (imem_ra !== 9'h000) begin
      bad++; $display("FAIL wrap_ra got=%h want=000", imem_ra);
    end
    tick();
    want = exp_q.pop_front();
    total++;
    if (ifid.if_valid !== 1'b1 || {ifid.if_pc, ifid.if_instr, ifid.if_pc_plus4} !== want) begin
      bad++; $display("FAIL wrap_000 got=%h/%h want=%h", ifid.if_pc, ifid.if_instr, want);
    end
  endtask

  task automatic test_misaligned();
    logic [IW-1:0] want;
    redirect_valid = 1'b1;
    redirect_pc    = 9'h056;
    tick();
    total++;
    if (fetch_err !== 1'b1 || ifid.if_valid !== 1'b0 || imem_ra !== 9'h004 || dbg_state !== 2'd2) begin
      bad++; $display("FAIL misalign got=e%b v%b ra=%h st=%0d want=e1 v0 004 2", fetch_err, ifid.if_valid, imem_ra, dbg_state);
    end
    redirect_pc = 9'h000;
    for (int i = 0; i < 10; i++) begin
      halt_req      = 1'($urandom_range(0, 1));
      ifid.if_ready = 1'($urandom_range(0, 1));
      tick();
      total++;
      if (fetch_err !== 1'b1 || ifid.if_valid !== 1'b0 || imem_ra !== 9'h004) begin
        bad++; $display("FAIL err_sticky_%0d got=e%b v%b ra=%h want=e1 v0 004", i, fetch_err, ifid.if_valid, imem_ra);
      end
    end
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    ifid.if_ready  = 1'b1;
    rst_n          = 1'b0;
    #1;
    total++;
    if (fetch_err !== 1'b0 || ifid.if_valid !== 1'b0 || imem_ra !== 9'h000 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL async_reset got=e%b v%b ra=%h st=%0d want=e0 v0 000 0", fetch_err, ifid.if_valid, imem_ra, dbg_state);
    end
    tick();
    rst_n = 1'b1;
    exp_q.push_back(exp_item(9'h000));
    tick();
    want = exp_q.pop_front();
    total++;
    if (ifid.if_valid !== 1'b1 || {ifid.if_pc, ifid.if_instr, ifid.if_pc_plus4} !== want) begin
      bad++; $display("FAIL post_reset got=v%b %h/%h want=%h", ifid.if_valid, ifid.if_pc, ifid.if_instr, want);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_halt();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_misaligned();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter and drives the memory read address.
- Memory read data returns combinationally in the same cycle. The block registers it, with its PC, into an IF/ID output register toward decode, using a valid/ready handshake.
- Accepts branch/jump redirects from execute, supports a halt request, and flags misaligned redirect targets.

Parameters:
- INS_ADDRESS, 9, byte-address width of PC and memory read address.
- INS_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset; must be word aligned.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_ra  out  INS_ADDRESS  read address to instruction memory; equals PC register.
- imem_rd  in  INS_W  instruction from memory, valid in the same cycle as imem_ra.
- redirect_valid  in  1  taken branch/jal/jalr this cycle.
- redirect_pc  in  INS_ADDRESS  redirect target byte address.
- halt_req  in  1  stop fetching.
- if_valid  out  1  IF/ID register holds an instruction.
- if_ready  in  1  decode accepts the instruction this cycle.
- if_instr  out  INS_W  registered instruction.
- if_pc  out  INS_ADDRESS  byte address of if_instr.
- if_pc_plus4  out  INS_ADDRESS  if_pc + 4, modulo 2^INS_ADDRESS (jal/jalr link value).
- fetch_err  out  1  sticky misaligned-redirect error.

Behaviour:
- Reset values (asynchronous, while rst_n = 0):
  - PC = RESET_PC; state = RUN.
  - if_valid = 0; if_instr = 0; if_pc = 0; if_pc_plus4 = 0; fetch_err = 0.
- States: RUN, HALT, ERR.
- load = (if_valid = 0) or (if_ready = 1).
- RUN, no redirect, halt_req = 0, load = 1:
  - capture imem_rd, PC and PC+4 into if_instr, if_pc, if_pc_plus4; if_valid <= 1.
  - PC <= PC+4.
  - Latency: address to if_instr is one cycle; with decode always ready, throughput is one instruction per cycle.
- RUN, load = 0 (stall): PC and the output register hold; imem_ra is stable.
- Redirect (redirect_valid = 1, redirect_pc[1:0] = 0) has priority over stall, halt and capture:
  - PC <= redirect_pc; if_valid <= 0 (wrong-path flush, regardless of if_ready).
  - State <= RUN, also from HALT.
  - First target instruction appears with if_valid = 1 two edges after the redirect cycle.
- Misaligned redirect (redirect_valid = 1, redirect_pc[1:0] != 0), from RUN or HALT:
  - state <= ERR; fetch_err <= 1; if_valid <= 0; PC unchanged.
- ERR:
  - absorbing until reset; all inputs ignored; fetch_err = 1; if_valid = 0.
- halt_req = 1 in RUN with no redirect:
  - state <= HALT; no capture that cycle; PC holds.
  - An already-valid output stays until accepted with if_ready = 1, then if_valid <= 0.
- HALT:
  - no new fetch; halt_req ignored.
  - Exits only on an aligned redirect, or to ERR on a misaligned one.
- Wrap-around: PC+4 wraps modulo 2^INS_ADDRESS (0x1FC -> 0x000 at default width).
- Simultaneous redirect and if_ready = 1 with if_valid = 1: the current output counts as consumed, and the flush still applies.
- Reset asserted mid-stall or mid-redirect: immediate return to reset values; the first capture occurs on the first edge after release.

Test Plan:
- Reset release, if_ready = 1, memory at default program:
  - edge 1 -> if_valid = 1, if_pc = 0x000, if_instr = 0x00007033.
  - edge 2 -> if_pc = 0x004, if_instr = 0x00100093, if_pc_plus4 = 0x008.
- Hold if_ready = 0 for 3 cycles with if_pc = 0x008 -> if_instr stays 0x00200113, imem_ra stays 0x00C. Release -> next if_pc = 0x00C.
- Redirect to 0x054 while stalled with valid output -> next cycle if_valid = 0, imem_ra = 0x054. Following cycle -> if_pc = 0x054, if_instr = 0x00008413.
- Misaligned redirect 0x056 -> fetch_err = 1 and if_valid = 0 on next edge. Both persist for 10 cycles despite an aligned redirect to 0x000, until rst_n pulses low.
- halt_req for 1 cycle at PC 0x010 -> imem_ra holds 0x010, if_valid clears after acceptance. Redirect to 0x030 -> RUN, if_pc = 0x030, if_instr = 0x0014c263.
- Redirect to 0x1FC -> captured if_pc_plus4 = 0x000, next imem_ra = 0x000 (wrap).
